// File: rtl/cmp_arith_pkg.sv
// Shared types for the compare/arithmetic pipeline.
// Optional saturation is enabled by defining CMP_ARITH_SAT_EN.
package cmp_arith_pkg;

    typedef enum logic [1:0] {
        OP_CMPSEL  = 2'd0,
        OP_ADD     = 2'd1,
        OP_SUB     = 2'd2,
        OP_ABSDIFF = 2'd3
    } op_e;

    // Compare-select resolves to an add when A > B.
    function automatic logic op_is_add(input op_e op, input logic gt);
        return (op == OP_ADD) || ((op == OP_CMPSEL) && gt);
    endfunction

endpackage

// File: rtl/cmp_arith_alu.sv
// Stage-2 arithmetic: add/sub/absdiff with carry-borrow flag.
// Defining CMP_ARITH_SAT_EN clamps overflowing results.
module cmp_arith_alu
    import cmp_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic             gt,
    output logic [WIDTH-1:0] res,
    output logic             flag
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           is_add;
    logic           is_abs;

    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};
    assign is_add = op_is_add(op, gt);
    assign is_abs = (op == OP_ABSDIFF);

    always_comb begin
        res  = '0;
        flag = 1'b0;
        unique case (1'b1)
            is_abs: begin
                res  = gt ? diff[WIDTH-1:0] : (b - a);
                flag = 1'b0;
            end
            is_add: begin
                res  = sum[WIDTH-1:0];
                flag = sum[WIDTH];
            end
            default: begin
                res  = diff[WIDTH-1:0];
                flag = diff[WIDTH];
            end
        endcase
`ifdef CMP_ARITH_SAT_EN
        if (flag) begin
            res = is_add ? '1 : '0;
        end
`else
`endif
    end

endmodule

// File: rtl/cmp_arith_pipe.sv
// Two-stage valid/ready compare-select arithmetic pipeline.
// Define CMP_ARITH_SAT_EN for saturating results.
module cmp_arith_pipe
    import cmp_arith_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [1:0]           OP,
    input  logic                 IVALID,
    output logic                 IREADY,
    output logic [WIDTH-1:0]     XOUT,
    output logic                 XFLAG,
    output logic                 XVALID,
    input  logic                 XREADY,
    output logic [CNT_WIDTH-1:0] CNT
);

    logic             v1;
    logic             v2;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    op_e              op1;
    logic             gt1;
    logic             acc;
    logic             adv;
    logic             drain;
    logic [WIDTH-1:0] res;
    logic             flag;

    assign IREADY = !v1 || !v2 || XREADY;
    assign acc    = IVALID && IREADY;
    assign drain  = v2 && XREADY;
    // Stage 1 moves on when stage 2 is empty or emptying this cycle.
    assign adv    = v1 && (!v2 || XREADY);
    assign XVALID = v2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            op1 <= OP_CMPSEL;
            gt1 <= 1'b0;
        end else if (acc) begin
            v1  <= 1'b1;
            a1  <= A;
            b1  <= B;
            op1 <= op_e'(OP);
            gt1 <= (A > B);
        end else if (adv) begin
            v1  <= 1'b0;
        end
    end

    cmp_arith_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a    (a1),
        .b    (b1),
        .op   (op1),
        .gt   (gt1),
        .res  (res),
        .flag (flag)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v2    <= 1'b0;
            XOUT  <= '0;
            XFLAG <= 1'b0;
            CNT   <= '0;
        end else begin
            if (adv) begin
                v2    <= 1'b1;
                XOUT  <= res;
                XFLAG <= flag;
            end else if (drain) begin
                v2    <= 1'b0;
            end
            if (drain) begin
                CNT <= CNT + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmp_arith_pipe.sv
// Directed bench for cmp_arith_pipe with a queue-based reference model.
module tb_cmp_arith_pipe;

`ifdef CMP_ARITH_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [1:0] OP = '0;
    logic       IVALID = 1'b0;
    logic       IREADY;
    logic [7:0] XOUT;
    logic       XFLAG;
    logic       XVALID;
    logic       XREADY = 1'b0;
    logic [3:0] CNT;

    cmp_arith_pipe #(
        .WIDTH     (8),
        .CNT_WIDTH (4)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .A      (A),
        .B      (B),
        .OP     (OP),
        .IVALID (IVALID),
        .IREADY (IREADY),
        .XOUT   (XOUT),
        .XFLAG  (XFLAG),
        .XVALID (XVALID),
        .XREADY (XREADY),
        .CNT    (CNT)
    );

    always #5 CLK = ~CLK;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int ndrain = 0;
    int first_drain = 0;
    int last_drain = 0;
    int mcnt = 0;
    logic [8:0] q[$];
    logic       stall = 1'b0;
    logic [8:0] held = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Result as {flag, value} from plain integer arithmetic.
    function automatic logic [8:0] model(input int a, input int b, input int op);
        int r;
        bit f;
        bit add;
        add = (op == 1) || (op == 0 && a > b);
        if (op == 3) begin
            r = (a > b) ? a - b : b - a;
            f = 1'b0;
        end else if (add) begin
            r = a + b;
            f = (r > 255);
            if (f) r = SAT ? 255 : r - 256;
        end else begin
            r = a - b;
            f = (r < 0);
            if (f) r = SAT ? 0 : r + 256;
        end
        return {f, 8'(r)};
    endfunction

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        logic [8:0] exp;
        if (RST) begin
            q.delete();
            mcnt = 0;
            stall = 1'b0;
        end else begin
            check("cnt", 32'(CNT), 32'(mcnt));
            if (stall) begin
                check("hold_valid", 32'(XVALID), 32'd1);
                check("hold_out", 32'({XFLAG, XOUT}), 32'(held));
            end
            if (XVALID && q.size() == 0) begin
                check("stale_valid", 32'(XVALID), 32'd0);
            end else if (XVALID && XREADY) begin
                exp = q.pop_front();
                check("result", 32'({XFLAG, XOUT}), 32'(exp));
                ndrain++;
                if (ndrain == 1) first_drain = cyc;
                last_drain = cyc;
                mcnt = (mcnt + 1) % 16;
            end
            stall = XVALID && !XREADY;
            held = {XFLAG, XOUT};
            if (IVALID && IREADY) q.push_back(model(A, B, OP));
        end
    end

    task automatic do_reset();
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        ndrain = 0;
    endtask

    task automatic send(input int a, input int b, input int op);
        bit acc;
        acc = 1'b0;
        A = 8'(a);
        B = 8'(b);
        OP = 2'(op);
        IVALID = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge CLK);
            acc = IREADY;
            @(posedge CLK);
            #1;
        end
        IVALID = 1'b0;
        check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            done = (q.size() == 0) && !XVALID;
        end
        check("drain_pending", 32'(q.size()), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic single(input string name, input int a, input int b,
                          input int op, input int eout, input int eflag);
        XREADY = 1'b1;
        A = 8'(a);
        B = 8'(b);
        OP = 2'(op);
        IVALID = 1'b1;
        @(negedge CLK);
        check({name, "_ready"}, 32'(IREADY), 32'd1);
        @(posedge CLK);
        #1 IVALID = 1'b0;
        @(negedge CLK);
        check({name, "_early"}, 32'(XVALID), 32'd0);
        @(negedge CLK);
        check({name, "_valid"}, 32'(XVALID), 32'd1);
        check({name, "_xout"}, 32'(XOUT), 32'(eout));
        check({name, "_xflag"}, 32'(XFLAG), 32'(eflag));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_xvalid", 32'(XVALID), 32'd0);
        check("rst_cnt", 32'(CNT), 32'd0);
        check("rst_xout", 32'(XOUT), 32'd0);
        check("rst_xflag", 32'(XFLAG), 32'd0);
        check("model_add", 32'(model(200, 100, 0)), {23'd0, 1'b1, SAT ? 8'd255 : 8'd44});
        check("model_sub", 32'(model(5, 9, 0)), {23'd0, 1'b1, SAT ? 8'd0 : 8'd252});
        check("model_abs", 32'(model(5, 9, 3)), 32'd4);
        @(posedge CLK);
        #1 RST = 1'b0;

        single("cmp_add", 200, 100, 0, SAT ? 255 : 44, 1);
        single("cmp_eq", 7, 7, 0, 0, 0);
        single("cmp_sub", 5, 9, 0, SAT ? 0 : 252, 1);
        single("absdiff", 5, 9, 3, 4, 0);
        single("add", 250, 10, 1, SAT ? 255 : 4, 1);
        single("sub", 9, 5, 2, 4, 0);

        do_reset();
        XREADY = 1'b1;
        A = 8'd0;
        IVALID = 1'b1;
        for (int i = 0; i < 8; i++) begin
            A = 8'(i * 37 + 3);
            B = 8'(i * 23 + 11);
            OP = 2'(i % 4);
            @(posedge CLK);
            #1;
        end
        IVALID = 1'b0;
        wait_empty();
        check("tput_count", 32'(ndrain), 32'd8);
        check("tput_consec", 32'(last_drain - first_drain), 32'd7);
        check("tput_cnt", 32'(CNT), 32'd8);

        do_reset();
        XREADY = 1'b0;
        send(10, 3, 1);
        send(50, 60, 2);
        @(negedge CLK);
        check("bp_iready", 32'(IREADY), 32'd0);
        A = 8'd200;
        B = 8'd1;
        OP = 2'd3;
        IVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("bp_stall_iready", 32'(IREADY), 32'd0);
        end
        @(posedge CLK);
        #1 XREADY = 1'b1;
        send(200, 1, 3);
        wait_empty();
        check("bp_count", 32'(ndrain), 32'd3);
        check("bp_cnt", 32'(CNT), 32'd3);

        do_reset();
        XREADY = 1'b1;
        send(1, 2, 1);
        wait_empty();
        XREADY = 1'b0;
        send(3, 4, 1);
        send(5, 6, 1);
        RST = 1'b1;
        #1;
        check("midrst_xvalid", 32'(XVALID), 32'd0);
        check("midrst_cnt", 32'(CNT), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        XREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("midrst_nostale", 32'(XVALID), 32'd0);
        end
        @(posedge CLK);
        #1;
        single("post_rst", 100, 50, 2, 50, 0);

        do_reset();
        XREADY = 1'b1;
        IVALID = 1'b1;
        for (int i = 0; i < 17; i++) begin
            A = 8'(i * 15);
            B = 8'(255 - i * 9);
            OP = 2'(i % 4);
            @(posedge CLK);
            #1;
        end
        IVALID = 1'b0;
        wait_empty();
        check("wrap_count", 32'(ndrain), 32'd17);
        check("wrap_cnt", 32'(CNT), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
